// File: rtl/vc_rr_switch.sv
// Virtual-channel switch: steers ingress words into per-VC FIFOs by their VC field, then
// forwards one word per cycle to a destination chosen by the head word's destination field,
// arbitrating round-robin across VCs and honouring per-destination pause.
module vc_rr_switch #(
  parameter int unsigned WORD_SIZE = 6,
  parameter int unsigned N_VC      = 2,
  parameter int unsigned N_DEST    = 2,
  parameter int unsigned VC_DEPTH  = 16,
  parameter int unsigned PTR_L     = 5
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [PTR_L-1:0]     umbral_V_full,
  input  logic [PTR_L-1:0]     umbral_V_empty,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 push_in,
  input  logic [N_DEST-1:0]    pause_dest,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [N_DEST-1:0]    dest_out,
  output logic [N_VC-1:0]      vc_pause,
  output logic [N_VC-1:0]      vc_almost_empty,
  output logic [N_VC-1:0]      vc_empty,
  output logic [N_VC-1:0]      errors,
  output logic                 error_out,
  output logic                 idle_out,
  output logic                 active_out
);

  localparam int unsigned VcBits   = $clog2(N_VC);
  localparam int unsigned DestBits = $clog2(N_DEST);
  localparam int unsigned AddrW    = $clog2(VC_DEPTH);
  localparam logic [PTR_L-1:0] DepthCnt = PTR_L'(VC_DEPTH);

  typedef enum logic [2:0] {StReset, StInit, StIdle, StActive, StError} state_e;

  state_e                 state_q, state_d;
  logic [WORD_SIZE-1:0]   mem_q [N_VC][VC_DEPTH];
  logic [AddrW-1:0]       wr_ptr_q [N_VC];
  logic [AddrW-1:0]       rd_ptr_q [N_VC];
  logic [PTR_L-1:0]       cnt_q [N_VC];
  logic [PTR_L-1:0]       full_thr_q, empty_thr_q;
  logic [VcBits-1:0]      rr_q;
  logic [WORD_SIZE-1:0]   data_out_q;
  logic                   valid_q;
  logic [N_DEST-1:0]      dest_q;
  logic [N_VC-1:0]        errors_q;

  logic                   run;
  logic [VcBits-1:0]      push_vc;
  logic                   overflow, push_ok;
  logic [N_VC-1:0]        elig, push_v, pop_v;
  logic                   pop_valid;
  logic [VcBits-1:0]      pop_vc, idx;
  logic [WORD_SIZE-1:0]   pop_word;
  logic [DestBits-1:0]    pop_dest;
  logic [N_DEST-1:0]      pop_dest_oh;

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(VC_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign run      = (state_q == StIdle) || (state_q == StActive);
  assign push_vc  = data_in[WORD_SIZE-1 -: VcBits];
  // Overflow is judged on the registered count, so a same-cycle pop does not rescue it.
  assign overflow = run && push_in && (cnt_q[push_vc] == DepthCnt);
  assign push_ok  = run && push_in && !overflow;

  // Per-VC eligibility and status flags from registered counts and the head word.
  always_comb begin
    elig = '0;
    for (int v = 0; v < N_VC; v++) begin
      elig[v] = run && (cnt_q[v] != '0) &&
                !pause_dest[mem_q[v][rd_ptr_q[v]][WORD_SIZE-VcBits-1 -: DestBits]];
      vc_pause[v]        = cnt_q[v] >= full_thr_q;
      vc_almost_empty[v] = cnt_q[v] <= empty_thr_q;
      vc_empty[v]        = cnt_q[v] == '0;
      push_v[v]          = push_ok && (push_vc == VcBits'(v));
    end
  end

  // Round-robin search starting just above the last granted VC.
  always_comb begin
    pop_valid = 1'b0;
    pop_vc    = '0;
    idx       = '0;
    for (int i = 1; i <= N_VC; i++) begin
      idx = rr_q + VcBits'(i);
      if (!pop_valid && elig[idx]) begin
        pop_valid = 1'b1;
        pop_vc    = idx;
      end
    end
    pop_word    = mem_q[pop_vc][rd_ptr_q[pop_vc]];
    pop_dest    = pop_word[WORD_SIZE-VcBits-1 -: DestBits];
    pop_dest_oh = '0;
    pop_dest_oh[pop_dest] = 1'b1;
    pop_v = '0;
    pop_v[pop_vc] = pop_valid;
  end

  // Control state machine; overflow overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StInit;
      StInit:   if (!init) state_d = StIdle;
      StIdle:   if (init) state_d = StInit;
                else if (~&vc_empty) state_d = StActive;
      StActive: if (init) state_d = StInit;
                else if (&vc_empty) state_d = StIdle;
      StError:  state_d = StError;
      default:  state_d = StReset;
    endcase
    if (overflow) state_d = StError;
  end

  // FIFO storage; contents need no reset since counts gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[push_vc][wr_ptr_q[push_vc]] <= data_in;
  end

  // State, thresholds, pointers, counts and the registered egress stage.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StReset;
      full_thr_q  <= DepthCnt;
      empty_thr_q <= '0;
      rr_q        <= VcBits'(N_VC - 1);
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      dest_q      <= '0;
      errors_q    <= '0;
      for (int v = 0; v < N_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StInit) begin
        full_thr_q  <= umbral_V_full;
        empty_thr_q <= umbral_V_empty;
      end
      valid_q <= pop_valid;
      dest_q  <= pop_valid ? pop_dest_oh : '0;
      if (pop_valid) begin
        data_out_q <= pop_word;
        rr_q       <= pop_vc;
      end
      if (overflow) errors_q[push_vc] <= 1'b1;
      for (int v = 0; v < N_VC; v++) begin
        if (push_v[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
        if (pop_v[v])  rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
        if (push_v[v] && !pop_v[v])      cnt_q[v] <= cnt_q[v] + 1'b1;
        else if (!push_v[v] && pop_v[v]) cnt_q[v] <= cnt_q[v] - 1'b1;
      end
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_q;
  assign dest_out   = dest_q;
  assign errors     = errors_q;
  assign error_out  = (state_q == StError);
  assign idle_out   = (state_q == StIdle);
  assign active_out = (state_q == StActive);

endmodule

// File: tb/tb_vc_rr_switch.sv
// Bench for vc_rr_switch: directed scenarios followed by random traffic, every cycle compared
// against a queue-based reference model of the switch behaviour.
module tb_vc_rr_switch;

  localparam int WORD_SIZE = 6;
  localparam int N_VC      = 2;
  localparam int N_DEST    = 2;
  localparam int VC_DEPTH  = 16;
  localparam int PTR_L     = 5;
  localparam int VC_BITS   = $clog2(N_VC);
  localparam int DEST_BITS = $clog2(N_DEST);

  localparam int MReset = 0, MInit = 1, MIdle = 2, MActive = 3, MError = 4;

  logic                 clk;
  logic                 reset_L;
  logic                 init;
  logic [PTR_L-1:0]     umbral_V_full;
  logic [PTR_L-1:0]     umbral_V_empty;
  logic [WORD_SIZE-1:0] data_in;
  logic                 push_in;
  logic [N_DEST-1:0]    pause_dest;
  logic [WORD_SIZE-1:0] data_out;
  logic                 valid_out;
  logic [N_DEST-1:0]    dest_out;
  logic [N_VC-1:0]      vc_pause, vc_almost_empty, vc_empty, errors;
  logic                 error_out, idle_out, active_out;

  vc_rr_switch #(
    .WORD_SIZE(WORD_SIZE), .N_VC(N_VC), .N_DEST(N_DEST), .VC_DEPTH(VC_DEPTH), .PTR_L(PTR_L)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .umbral_V_full   (umbral_V_full),
    .umbral_V_empty  (umbral_V_empty),
    .data_in         (data_in),
    .push_in         (push_in),
    .pause_dest      (pause_dest),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .dest_out        (dest_out),
    .vc_pause        (vc_pause),
    .vc_almost_empty (vc_almost_empty),
    .vc_empty        (vc_empty),
    .errors          (errors),
    .error_out       (error_out),
    .idle_out        (idle_out),
    .active_out      (active_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [WORD_SIZE-1:0] vcq [N_VC][$];
  int                   m_st, m_rr, m_full, m_empty, m_dest;
  logic [WORD_SIZE-1:0] m_data;
  bit                   m_valid;
  logic [N_VC-1:0]      m_err;

  function automatic int vc_of(input logic [WORD_SIZE-1:0] w);
    return int'(w) >> (WORD_SIZE - VC_BITS);
  endfunction

  function automatic int dest_of(input logic [WORD_SIZE-1:0] w);
    return (int'(w) >> (WORD_SIZE - VC_BITS - DEST_BITS)) % N_DEST;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N_VC; v++) vcq[v].delete();
    m_st = MReset; m_rr = N_VC - 1; m_full = VC_DEPTH; m_empty = 0;
    m_data = '0; m_valid = 0; m_dest = 0; m_err = '0;
  endtask

  // One clock edge of the switch, computed from the pre-edge inputs.
  task automatic model_edge();
    int pv, vin, nst;
    bit run, ov, acc, any;
    if (!reset_L) begin
      model_reset();
      return;
    end
    run = (m_st == MIdle) || (m_st == MActive);
    pv = -1;
    if (run) begin
      for (int i = 1; i <= N_VC; i++) begin
        int v;
        v = (m_rr + i) % N_VC;
        if (pv < 0 && vcq[v].size() > 0 && !pause_dest[dest_of(vcq[v][0])]) pv = v;
      end
    end
    vin = vc_of(data_in);
    ov  = run && push_in && (vcq[vin].size() == VC_DEPTH);
    acc = run && push_in && !ov;
    any = 0;
    for (int v = 0; v < N_VC; v++) if (vcq[v].size() > 0) any = 1;
    nst = m_st;
    case (m_st)
      MReset:  nst = MInit;
      MInit:   if (!init) nst = MIdle;
      MIdle:   nst = init ? MInit : (any ? MActive : MIdle);
      MActive: nst = init ? MInit : (any ? MActive : MIdle);
      default: nst = m_st;
    endcase
    if (ov) nst = MError;
    if (m_st == MInit) begin
      m_full  = int'(umbral_V_full);
      m_empty = int'(umbral_V_empty);
    end
    if (pv >= 0) begin
      m_data  = vcq[pv].pop_front();
      m_valid = 1;
      m_dest  = 1 << dest_of(m_data);
      m_rr    = pv;
    end else begin
      m_valid = 0;
      m_dest  = 0;
    end
    if (acc) vcq[vin].push_back(data_in);
    if (ov) m_err[vin] = 1'b1;
    m_st = nst;
  endtask

  task automatic check_all();
    logic [N_VC-1:0] e_pause, e_ae, e_empty;
    for (int v = 0; v < N_VC; v++) begin
      e_pause[v] = int'(vcq[v].size()) >= m_full;
      e_ae[v]    = int'(vcq[v].size()) <= m_empty;
      e_empty[v] = vcq[v].size() == 0;
    end
    check("data_out", 32'(data_out), 32'(m_data));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("dest_out", 32'(dest_out), 32'(m_dest));
    check("vc_pause", 32'(vc_pause), 32'(e_pause));
    check("vc_almost_empty", 32'(vc_almost_empty), 32'(e_ae));
    check("vc_empty", 32'(vc_empty), 32'(e_empty));
    check("errors", 32'(errors), 32'(m_err));
    check("error_out", 32'(error_out), 32'(m_st == MError));
    check("idle_out", 32'(idle_out), 32'(m_st == MIdle));
    check("active_out", 32'(active_out), 32'(m_st == MActive));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset(input int full_thr, input int empty_thr);
    push_in = 0; init = 0; reset_L = 0;
    model_reset();
    #1;
    check_all();
    step();
    reset_L = 1; init = 1;
    umbral_V_full = PTR_L'(full_thr); umbral_V_empty = PTR_L'(empty_thr);
    step();
    step();
    init = 0;
    step();
  endtask

  logic [WORD_SIZE-1:0] exp3 [8] = '{6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23, 6'h04, 6'h24};

  initial begin
    reset_L = 1; init = 0; push_in = 0; data_in = '0; pause_dest = '0;
    umbral_V_full = '0; umbral_V_empty = '0;
    model_reset();
    #1;
    // 1: reset values, then threshold load and INIT -> IDLE
    reset_L = 0;
    #1;
    check_all();
    check("rst_vc_empty", 32'(vc_empty), 32'h3);
    check("rst_ae", 32'(vc_almost_empty), 32'h3);
    check("rst_valid", 32'(valid_out), 32'h0);
    step();
    reset_L = 1; init = 1; umbral_V_full = 5'd12; umbral_V_empty = 5'd2;
    step();
    step();
    init = 0;
    step();
    check("t1_idle", 32'(idle_out), 32'h1);

    // 2: single word, one-cycle latency
    data_in = 6'h21; push_in = 1;
    step();
    push_in = 0;
    step();
    check("t2_data", 32'(data_out), 32'h21);
    check("t2_valid", 32'(valid_out), 32'h1);
    check("t2_dest", 32'(dest_out), 32'h1);
    check("t2_active", 32'(active_out), 32'h1);
    step();
    check("t2_valid_low", 32'(valid_out), 32'h0);
    check("t2_idle", 32'(idle_out), 32'h1);

    // 3: round-robin interleave across two loaded VCs
    pause_dest = 2'b11; push_in = 1;
    for (int i = 1; i <= 4; i++) begin
      data_in = WORD_SIZE'(i); step();
      data_in = WORD_SIZE'(8'h20 + i); step();
    end
    push_in = 0; pause_dest = 2'b00;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_order", 32'(data_out), 32'(exp3[i]));
      check("t3_valid", 32'(valid_out), 32'h1);
    end
    step();

    // 4: paused head blocks its VC only
    pause_dest = 2'b11; push_in = 1;
    data_in = 6'h11; step();
    data_in = 6'h20; step();
    push_in = 0; pause_dest = 2'b10;
    step();
    check("t4_data", 32'(data_out), 32'h20);
    check("t4_dest", 32'(dest_out), 32'h1);
    step();
    check("t4_held", 32'(valid_out), 32'h0);
    check("t4_vc0_nonempty", 32'(vc_empty[0]), 32'h0);
    pause_dest = 2'b00;
    step();
    check("t4_release", 32'(data_out), 32'h11);
    check("t4_dest1", 32'(dest_out), 32'h2);
    step();

    // 5: almost-empty and almost-full thresholds on VC0
    pause_dest = 2'b11; push_in = 1;
    for (int i = 1; i <= 12; i++) begin
      data_in = WORD_SIZE'(i - 1);
      step();
      if (i == 2)  check("t5_ae_at2", 32'(vc_almost_empty[0]), 32'h1);
      if (i == 3)  check("t5_ae_at3", 32'(vc_almost_empty[0]), 32'h0);
      if (i == 11) check("t5_pause_at11", 32'(vc_pause[0]), 32'h0);
      if (i == 12) check("t5_pause_at12", 32'(vc_pause[0]), 32'h1);
    end
    push_in = 0; pause_dest = 2'b00;
    for (int i = 0; i < 13; i++) step();

    // 6: overflow on the 17th push is sticky until reset
    pause_dest = 2'b11; push_in = 1;
    for (int i = 1; i <= 17; i++) begin
      data_in = WORD_SIZE'(i - 1);
      step();
      if (i == 16) check("t6_no_err_16", 32'(error_out), 32'h0);
    end
    check("t6_errors", 32'(errors), 32'h1);
    check("t6_error_out", 32'(error_out), 32'h1);
    push_in = 0; pause_dest = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_valid", 32'(valid_out), 32'h0);
    end

    // Random traffic against the model; the last round leans on pause to provoke overflow.
    for (int r = 0; r < 3; r++) begin
      do_reset(int'($urandom_range(1, 16)), int'($urandom_range(0, 15)));
      for (int c = 0; c < 300; c++) begin
        push_in    = ($urandom_range(0, 9) < 6);
        data_in    = WORD_SIZE'($urandom);
        init       = ($urandom_range(0, 49) == 0);
        pause_dest = (r == 2 && $urandom_range(0, 3) != 0) ? 2'b11 : N_DEST'($urandom);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vc_rr_switch.md
Name: vc_rr_switch

Overview:
Parametrised successor to the fixed two-VC main-to-destination path. Incoming words are steered into N_VC internal virtual-channel FIFOs by their VC field. A round-robin arbiter then forwards one word per cycle to one of N_DEST destinations, chosen by the word's destination field, while honouring per-destination pause. The block includes the RESET/INIT/IDLE/ACTIVE/ERROR control machine with programmable VC thresholds and sticky per-VC overflow errors. It sits between the main FIFO pop logic and the destination FIFOs.

Parameters:
- WORD_SIZE, 6: word width in bits.
- N_VC, 2: number of virtual channels; power of 2, ≥2. Local VC_BITS = clog2(N_VC).
- N_DEST, 2: number of destinations; power of 2, ≥2. Local DEST_BITS = clog2(N_DEST).
- VC_DEPTH, 16: entries per VC FIFO.
- PTR_L, 5: threshold and count width; must be ≥ clog2(VC_DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  enter INIT; thresholds are captured while it is high.
- umbral_V_full  in  PTR_L  almost-full threshold.
- umbral_V_empty  in  PTR_L  almost-empty threshold.
- data_in  in  WORD_SIZE  ingress word. VC field = [WORD_SIZE-1 -: VC_BITS]; destination field = the next DEST_BITS bits below it.
- push_in  in  1  ingress write strobe.
- pause_dest  in  N_DEST  per-destination backpressure (almost_full of the destination FIFO).
- data_out  out  WORD_SIZE  registered egress word.
- valid_out  out  1  data_out is valid this cycle.
- dest_out  out  N_DEST  one-hot push to the destination FIFOs; zero when valid_out=0.
- vc_pause  out  N_VC  per-VC almost_full, fed back to the upstream pop logic.
- vc_almost_empty  out  N_VC  per-VC almost_empty.
- vc_empty  out  N_VC  per-VC empty.
- errors  out  N_VC  sticky per-VC overflow.
- error_out, idle_out, active_out  out  1 each  state indicators.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - State=RESET; all FIFOs and counts cleared; RR pointer = N_VC-1.
  - Internal thresholds: full = VC_DEPTH, empty = 0.
  - data_out=0, valid_out=0, dest_out=0, errors=0, error/idle/active=0, vc_pause=0, vc_empty=all 1, vc_almost_empty=all 1.
- FSM transitions, evaluated on clk:
  - RESET → INIT on the first edge after reset_L rises.
  - INIT: internal thresholds are loaded from the ports every cycle. Go to IDLE when init=0.
  - IDLE (idle_out=1): go to ACTIVE when any VC count is non-zero.
  - ACTIVE (active_out=1): go to IDLE when all counts are 0.
  - IDLE/ACTIVE → INIT when init=1. FIFO contents are kept.
  - Any state → ERROR on overflow. ERROR (error_out=1) is left only by reset_L=0.
- Push:
  - Accepted only in IDLE/ACTIVE. In RESET/INIT/ERROR a push is dropped silently.
  - Overflow: push_in=1 to a VC whose count==VC_DEPTH, regardless of a same-cycle pop. The word is dropped, errors[v] is set, and the FSM goes to ERROR on the same edge.
  - Same-cycle push and pop on a non-full VC: the count is unchanged.
- Arbitration (IDLE/ACTIVE only; there are no pops in other states):
  - VC v is eligible iff !vc_empty[v] and !pause_dest[dest field of v's head word]; pause_dest is sampled combinationally.
  - The grant goes to the first eligible VC searching upward, with wrap-around, from RR pointer+1. The RR pointer is then set to the granted VC.
  - No eligible VC → no pop; valid_out=0 and dest_out=0 next cycle.
  - Within a VC, words leave strictly in order; a paused head word blocks its VC.
- Latency and output timing:
  - A word pushed at edge k can appear on data_out with valid_out=1 after edge k+1 at the earliest.
  - dest_out is one-hot decoded from the destination field of data_out.
  - data_out holds its last value when valid_out=0.
- Flags (combinational from registered counts):
  - vc_pause[v] = count ≥ full threshold.
  - vc_almost_empty[v] = count ≤ empty threshold.
  - vc_empty[v] = count == 0.
- Pointers wrap modulo VC_DEPTH. Count ranges 0..VC_DEPTH.

Test Plan:
Defaults for all scenarios: WORD_SIZE=6, N_VC=2, N_DEST=2, VC_DEPTH=16.
1. reset_L=0 → every output at its reset value, vc_empty=2'b11. Release, init=1 with full=12, empty=2, then init=0 → idle_out=1 next edge.
2. Push 6'h21 (VC1, dest0) → after the next edge: data_out=6'h21, valid_out=1, dest_out=2'b01, active_out=1. Then valid_out=0 and idle_out=1.
3. With pause_dest=2'b11, load VC0 with 6'h01..04 and VC1 with 6'h21..24, then set pause_dest=0 → output order 01,21,02,22,03,23,04,24 on consecutive cycles.
4. VC0 head 6'h11 (dest1), VC1 head 6'h20 (dest0), pause_dest=2'b10 → only 6'h20 is forwarded; VC0 is held; vc_empty[0] stays 0.
5. With pause_dest=2'b11, push 12 words to VC0 → vc_almost_empty[0] falls after the 3rd push; vc_pause[0] rises after the 12th.
6. Push 17 words to VC0 with pause_dest=2'b11 → errors=2'b01, error_out=1 on the 17th edge; valid_out stays 0 until reset_L=0.
